// File: rtl/midi_msg_tx.sv
// midi_msg_tx
//   Builds a 3-byte MIDI channel message (status, note, velocity) from one
//   note event and shifts it out on a MIDI/UART line. Each byte is framed as
//   1 start bit, 8 data bits LSB first and 1 stop bit. Consecutive bytes of a
//   message are sent back to back with no idle gap.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//
// Ports:
//   i_clk          system clock, all logic on posedge
//   i_rst          asynchronous active-high reset
//   i_note_valid   event request, held until accepted
//   i_note_on      1 = Note On (0x9n), 0 = Note Off (0x8n)
//   i_channel      MIDI channel 0..15
//   i_note         note number 0..127
//   i_velocity     velocity 0..127
//   o_note_ready   high when an event can be accepted (FSM idle)
//   o_midi_tx      serial line, idles high
//   o_busy         high while a message is being shifted out
//   o_byte_done    one-cycle pulse in the last cycle of each stop bit
//
// Build option:
//   RUNNING_STATUS_EN  when defined, the status byte is omitted if it equals
//                      the status of the previously sent message.
//
// state | meaning
// IDLE  | line high, waiting for an event
// START | start bit (low)
// DATA  | 8 data bits, LSB first
// STOP  | stop bit (high), then next byte or IDLE
module midi_msg_tx #(
  parameter int CLKS_PER_BIT = 3200
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_note_valid,
  input  logic       i_note_on,
  input  logic [3:0] i_channel,
  input  logic [6:0] i_note,
  input  logic [6:0] i_velocity,
  output logic       o_note_ready,
  output logic       o_midi_tx,
  output logic       o_busy,
  output logic       o_byte_done
);

  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [1:0]    r_idx;
  logic [7:0]    r_byte0;
  logic [7:0]    r_byte1;
  logic [7:0]    r_byte2;
  logic          r_tx;

  logic       w_accept;
  logic       w_bit_end;
  logic       w_skip;
  logic [7:0] w_status;
  logic [7:0] w_cur_byte;
  logic [2:0] w_bit_nx;

  assign w_accept  = i_note_valid && (r_state == S_IDLE);
  assign w_bit_end = (r_baud == BAUD_LAST);
  assign w_status  = {1'b1, 2'b00, i_note_on, i_channel};
  assign w_bit_nx  = r_bit + 3'd1;

  always_comb begin
    w_cur_byte = r_byte0;
    case (r_idx)
      2'd1:    w_cur_byte = r_byte1;
      2'd2:    w_cur_byte = r_byte2;
      default: w_cur_byte = r_byte0;
    endcase
  end

`ifdef RUNNING_STATUS_EN
  // A status byte always has bit 7 set, so 0x00 can never match and serves
  // as the "no previous status" marker after reset.
  logic [7:0] r_last_status;

  assign w_skip = (w_status == r_last_status);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last_status <= 8'h00;
    end else if (w_accept && !w_skip) begin
      r_last_status <= w_status;
    end
  end
`else
  assign w_skip = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_byte0 <= 8'h00;
      r_byte1 <= 8'h00;
      r_byte2 <= 8'h00;
    end else if (w_accept) begin
      r_byte0 <= w_status;
      r_byte1 <= {1'b0, i_note};
      r_byte2 <= {1'b0, i_velocity};
    end
  end

  // The line is registered; each transition loads the level of the bit that
  // starts on the following cycle, so the start bit begins one cycle after
  // accept.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= 3'd0;
      r_idx   <= 2'd0;
      r_tx    <= 1'b1;
    end else begin
      if (r_state != S_IDLE) begin
        r_baud <= w_bit_end ? '0 : r_baud + 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_accept) begin
            r_state <= S_START;
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_idx   <= w_skip ? 2'd1 : 2'd0;
            r_tx    <= 1'b0;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_state <= S_DATA;
            r_bit   <= 3'd0;
            r_tx    <= w_cur_byte[0];
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            if (r_bit == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit <= w_bit_nx;
              r_tx  <= w_cur_byte[w_bit_nx];
            end
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            if (r_idx != 2'd2) begin
              r_state <= S_START;
              r_idx   <= r_idx + 2'd1;
              r_tx    <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_idx   <= 2'd0;
              r_tx    <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign o_note_ready = (r_state == S_IDLE);
  assign o_busy       = (r_state != S_IDLE);
  assign o_byte_done  = (r_state == S_STOP) && w_bit_end;
  assign o_midi_tx    = r_tx;

endmodule

// File: tb/tb_midi_msg_tx.sv
// Directed bench for midi_msg_tx with CLKS_PER_BIT = 4. Every cycle of each
// message is compared with the expected serial stream and byte_done timing.
module tb_midi_msg_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       note_valid;
  logic       note_on;
  logic [3:0] channel;
  logic [6:0] note;
  logic [6:0] velocity;
  logic       note_ready;
  logic       midi_tx;
  logic       busy;
  logic       byte_done;

  int n_tests = 0;
  int n_fail  = 0;

  midi_msg_tx #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_note_valid (note_valid),
    .i_note_on    (note_on),
    .i_channel    (channel),
    .i_note       (note),
    .i_velocity   (velocity),
    .o_note_ready (note_ready),
    .o_midi_tx    (midi_tx),
    .o_busy       (busy),
    .o_byte_done  (byte_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive an event and wait for it to be accepted; returns just after the
  // accepting edge.
  task automatic do_accept(input logic on, input logic [3:0] ch, input logic [6:0] nt,
                           input logic [6:0] vel, input bit hold);
    int w;
    note_on    = on;
    channel    = ch;
    note       = nt;
    velocity   = vel;
    note_valid = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!note_ready && w < 200);
    chk("accept_ready", {31'd0, note_ready}, 32'd1);
    @(posedge clk);
    #1;
    if (!hold) note_valid = 1'b0;
  endtask

  // Check a message cycle by cycle starting at the first negedge after the
  // accepting edge, then check the idle cycle that follows.
  task automatic run_msg(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input int nb, input bit scramble, input string tag);
    logic [7:0] bb [3];
    logic [7:0] by;
    logic       exp_tx;
    int j, p;
    bb[0] = b0;
    bb[1] = b1;
    bb[2] = b2;
    for (int k = 1; k <= nb * 40; k++) begin
      @(negedge clk);
      j  = (k - 1) / CPB;
      by = bb[j / 10];
      p  = j % 10;
      if (p == 0)      exp_tx = 1'b0;
      else if (p == 9) exp_tx = 1'b1;
      else             exp_tx = by[p-1];
      chk($sformatf("%s tx k=%0d", tag, k), {31'd0, midi_tx}, {31'd0, exp_tx});
      chk($sformatf("%s byte_done k=%0d", tag, k), {31'd0, byte_done},
          {31'd0, (k % 40) == 0});
      if ((k % CPB) == 1) begin
        chk($sformatf("%s busy k=%0d", tag, k), {31'd0, busy}, 32'd1);
        chk($sformatf("%s ready k=%0d", tag, k), {31'd0, note_ready}, 32'd0);
      end
      if (scramble) begin
        note_on    = 1'($urandom);
        channel    = 4'($urandom);
        note       = 7'($urandom);
        velocity   = 7'($urandom);
        note_valid = (k < nb * 40) ? 1'($urandom) : 1'b0;
      end
    end
    @(negedge clk);
    chk({tag, " end ready"}, {31'd0, note_ready}, 32'd1);
    chk({tag, " end busy"}, {31'd0, busy}, 32'd0);
    chk({tag, " end tx"}, {31'd0, midi_tx}, 32'd1);
    chk({tag, " end byte_done"}, {31'd0, byte_done}, 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    note_valid = 1'b0;
    note_on    = 1'b0;
    channel    = 4'd0;
    note       = 7'd0;
    velocity   = 7'd0;
    @(negedge clk);
    @(negedge clk);
    chk("reset tx", {31'd0, midi_tx}, 32'd1);
    chk("reset ready", {31'd0, note_ready}, 32'd1);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset byte_done", {31'd0, byte_done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Note On ch0 0x3C/0x64
    do_accept(1'b1, 4'd0, 7'h3C, 7'h64, 1'b0);
    run_msg(8'h90, 8'h3C, 8'h64, 3, 1'b0, "on_ch0");

    // Note Off ch15 0x7F/0x00
    do_accept(1'b0, 4'd15, 7'h7F, 7'h00, 1'b0);
    run_msg(8'h8F, 8'h7F, 8'h00, 3, 1'b0, "off_ch15");

    // Back to back: valid held, second event accepted right after final byte_done
    do_accept(1'b1, 4'd1, 7'h11, 7'h22, 1'b1);
    note_on  = 1'b0;
    channel  = 4'd2;
    note     = 7'h33;
    velocity = 7'h44;
    run_msg(8'h91, 8'h11, 8'h22, 3, 1'b0, "b2b_a");
    @(posedge clk);
    #1;
    note_valid = 1'b0;
    run_msg(8'h82, 8'h33, 8'h44, 3, 1'b0, "b2b_b");

    // Inputs scrambled every cycle while busy
    do_accept(1'b1, 4'd10, 7'h15, 7'h2A, 1'b0);
    run_msg(8'h9A, 8'h15, 8'h2A, 3, 1'b1, "scramble");

    // Reset during a data bit of byte 1
    do_accept(1'b1, 4'd0, 7'h3C, 7'h64, 1'b0);
    for (int k = 1; k <= 50; k++) @(negedge clk);
    chk("pre_reset tx", {31'd0, midi_tx}, 32'd0);
    chk("pre_reset busy", {31'd0, busy}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_reset tx", {31'd0, midi_tx}, 32'd1);
    chk("async_reset busy", {31'd0, busy}, 32'd0);
    chk("async_reset ready", {31'd0, note_ready}, 32'd1);
    chk("async_reset byte_done", {31'd0, byte_done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (midi_tx !== 1'b1 || busy !== 1'b0 || k == 50) begin
        chk($sformatf("post_reset idle k=%0d", k), {30'd0, midi_tx, busy}, 32'd2);
      end
    end

    // Running status sequence on channel 3
    do_accept(1'b1, 4'd3, 7'h40, 7'h50, 1'b0);
    run_msg(8'h93, 8'h40, 8'h50, 3, 1'b0, "rs_first");
    do_accept(1'b1, 4'd3, 7'h41, 7'h51, 1'b0);
`ifdef RUNNING_STATUS_EN
    run_msg(8'h41, 8'h51, 8'h00, 2, 1'b0, "rs_second");
`else
    run_msg(8'h93, 8'h41, 8'h51, 3, 1'b0, "rs_second");
`endif
    do_accept(1'b0, 4'd3, 7'h42, 7'h00, 1'b0);
    run_msg(8'h83, 8'h42, 8'h00, 3, 1'b0, "rs_third");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
